mxint_accumulator: RTL
======================

# mxint_accumulator

Accumulates a fixed number of consecutive MXINT partial dot products (one mantissa plus one shared exponent each) into a single MXINT result. It sits directly downstream of the MXINT dot-product stage in the MXINT linear layer. It reduces `BLOCK_NUM` block-level products along the input-feature dimension, aligning every operand to the larger exponent before adding.

## Interface
- `DATA_IN_0_PRECISION_0`, default 19: signed input mantissa width (dot-product output width).
- `DATA_IN_0_PRECISION_1`, default 9: signed input exponent width.
- `BLOCK_NUM`, default 4: number of inputs per accumulation group; must be ≥1.
- `DATA_OUT_0_PRECISION_0`, default `DATA_IN_0_PRECISION_0 + $clog2(BLOCK_NUM)`: signed output mantissa width.
- `DATA_OUT_0_PRECISION_1`, default `DATA_IN_0_PRECISION_1`: signed output exponent width.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `mdata_in_0` input `DATA_IN_0_PRECISION_0`: signed partial-product mantissa.
- `edata_in_0` input `DATA_IN_0_PRECISION_1`: signed partial-product exponent.
- `data_in_0_valid` input 1: input handshake valid.
- `data_in_0_ready` output 1: input handshake ready.
- `mdata_out_0` output `DATA_OUT_0_PRECISION_0`: signed accumulated mantissa.
- `edata_out_0` output `DATA_OUT_0_PRECISION_1`: signed accumulated exponent.
- `data_out_0_valid` output 1: output handshake valid.
- `data_out_0_ready` input 1: output handshake ready.

## Operation
- States: ACCUM (collecting a group) and HOLD (result registered, waiting for consumer). Group counter `cnt` runs 0..BLOCK_NUM-1.
- Input transfer: `data_in_0_valid && data_in_0_ready`. Output transfer: `data_out_0_valid && data_out_0_ready`.
- First input of a group (`cnt==0`): `acc_m` = sign-extended `mdata_in_0`; `acc_e` = `edata_in_0`.
- Later inputs: compute `d = edata_in_0 - acc_e` in `DATA_IN_0_PRECISION_1+1` signed bits.
  - If `d > 0`: `acc_m = (acc_m >>> d) + in_m`, then `acc_e = edata_in_0`.
  - Otherwise: `acc_m = acc_m + (in_m >>> -d)`, where `in_m` is first sign-extended to output width.
- Shifts are arithmetic and truncate toward −∞. A shift amount ≥ `DATA_OUT_0_PRECISION_0` yields all sign bits (0 or −1).
- Output width guarantees no overflow for equal-exponent inputs; no saturation logic.
- On the transfer of the BLOCK_NUM-th input: the final sum is written to `mdata_out_0`/`edata_out_0`, `cnt` returns to 0, and the state moves to HOLD.
- In HOLD, an output transfer returns the state to ACCUM.
- `BLOCK_NUM==1`: each input passes through sign-extended, one cycle later.

## Timing
- Reset values: `data_out_0_valid=0`, `mdata_out_0=0`, `edata_out_0=0`, `cnt=0`, state ACCUM.
- A reset asserted mid-group discards the partial sum; the next transferred input starts a new group.
- `data_in_0_ready = !data_out_0_valid || data_out_0_ready`. This is combinational from `data_out_0_ready`; there is no other input stall.
- Throughput: one input per cycle. `data_out_0_valid` rises the cycle after the last input transfers.
- Output data are registered and stay stable while `valid && !ready`.
- Simultaneous output transfer and input transfer in HOLD: the input is the first element of the next group, and valid drops unless BLOCK_NUM==1. When BLOCK_NUM==1, valid stays high with the new data.
- Accept-to-output latency for the group's last element: 1 cycle.

## Configuration
- `MXINT_ACCUMULATOR_ROUND_EN` defined: every alignment right shift by `s ≥ 1` adds bit `s-1` of the pre-shift operand (round half up). This applies to both the `acc_m` and `in_m` paths; shifts ≥ width still give the sign fill with no rounding.
- Undefined: pure truncation (floor), as described above.

## Test plan
Bench parameters: `DATA_IN_0_PRECISION_0=8`, `DATA_IN_0_PRECISION_1=4`, `BLOCK_NUM=4` (output 10/4 bits).

1. Equal exponents: inputs (10,2),(20,2),(30,2),(40,2) back-to-back -> one output (100,2), valid exactly one cycle after 4th transfer.
2. Rising exponent: (8,0),(4,2),(0,2),(0,2) -> (6,2).
3. Negative rounding: (−5,1),(16,3),(0,3),(0,3) -> (14,3) without macro; (15,3) with `MXINT_ACCUMULATOR_ROUND_EN`.
4. Over-range shift: (100,−8),(1,7),(0,7),(0,7) -> (1,7), since shift 15 ≥ 10 gives 0.
5. Backpressure: after a group completes, hold `data_out_0_ready=0` for 5 cycles -> output stable and `data_in_0_ready=0` throughout. Then raise ready with input valid in the same cycle -> output transfers, that input is counted as the first of the next group, and the next output is correct.
6. Reset mid-group: apply `rst` after 2 of 4 inputs -> all outputs 0 asynchronously. The next 4 inputs (1,0)×4 -> (4,0).

Source files
------------

// File: rtl/mxint_accumulator.sv
// mxint_accumulator: sums BLOCK_NUM consecutive MXINT (mantissa, exponent)
// partial products into one MXINT result, aligning to the larger exponent.
// Ports: clk, rst (async, active-high);
//   in:  mdata_in_0, edata_in_0, data_in_0_valid / data_in_0_ready;
//   out: mdata_out_0, edata_out_0, data_out_0_valid / data_out_0_ready.
// Optional macro MXINT_ACCUMULATOR_ROUND_EN: round-half-up on alignment
// shifts (default: truncate toward -inf).
module mxint_accumulator #(
  parameter int DATA_IN_0_PRECISION_0  = 19,
  parameter int DATA_IN_0_PRECISION_1  = 9,
  parameter int BLOCK_NUM              = 4,
  parameter int DATA_OUT_0_PRECISION_0 =
    DATA_IN_0_PRECISION_0 + $clog2(BLOCK_NUM),
  parameter int DATA_OUT_0_PRECISION_1 = DATA_IN_0_PRECISION_1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  mdata_in_0,
  input  logic [DATA_IN_0_PRECISION_1-1:0]  edata_in_0,
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] mdata_out_0,
  output logic [DATA_OUT_0_PRECISION_1-1:0] edata_out_0,
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready
);

  localparam int OW  = DATA_OUT_0_PRECISION_0;
  localparam int EW  = DATA_IN_0_PRECISION_1;
  localparam int OEW = DATA_OUT_0_PRECISION_1;
  localparam int CW  = (BLOCK_NUM > 1) ? $clog2(BLOCK_NUM) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_NUM - 1);
  localparam logic [EW:0]   SH_ONE   = (EW + 1)'(1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [OW-1:0]  acc_m_q, acc_m_d;
  logic [EW-1:0]         acc_e_q, acc_e_d;
  logic [OW-1:0]         mout_q, mout_d;
  logic [OEW-1:0]        eout_q, eout_d;
  logic                  valid_q, valid_d;

  logic                  in_fire;
  logic                  out_fire;
  logic signed [OW-1:0]  in_ext;
  logic signed [EW:0]    d;
  logic [EW:0]           shamt;
  logic signed [OW-1:0]  sum_m;
  logic [EW-1:0]         sum_e;

  // Arithmetic right shift; amounts past the width collapse to sign fill.
  function automatic logic signed [OW-1:0] align(
    input logic signed [OW-1:0] x,
    input logic [EW:0]          s
  );
    logic signed [OW-1:0] r;
`ifdef MXINT_ACCUMULATOR_ROUND_EN
    logic signed [OW-1:0] t;
`endif
    r = x;
    if (int'(s) >= OW) begin
      r = {OW{x[OW-1]}};
    end else if (s != '0) begin
      r = x >>> s;
`ifdef MXINT_ACCUMULATOR_ROUND_EN
      // Bit s-1 of the operand is the half-LSB being discarded.
      t = x >>> (s - SH_ONE);
      r = r + $signed({{(OW-1){1'b0}}, t[0]});
`endif
    end
    return r;
  endfunction

  assign data_in_0_ready  = !valid_q || data_out_0_ready;
  assign in_fire          = data_in_0_valid && data_in_0_ready;
  assign out_fire         = valid_q && data_out_0_ready;
  assign mdata_out_0      = mout_q;
  assign edata_out_0      = eout_q;
  assign data_out_0_valid = valid_q;

  always_comb begin
    in_ext = OW'($signed(mdata_in_0));
    d      = $signed({edata_in_0[EW-1], edata_in_0})
           - $signed({acc_e_q[EW-1], acc_e_q});
    shamt  = d[EW] ? (EW + 1)'(-d) : (EW + 1)'(d);
    sum_m  = in_ext;
    sum_e  = edata_in_0;
    if (cnt_q == '0) begin
      sum_m = in_ext;
      sum_e = edata_in_0;
    end else if (!d[EW] && (d != '0)) begin
      sum_m = align(acc_m_q, shamt) + in_ext;
      sum_e = edata_in_0;
    end else begin
      sum_m = acc_m_q + align(in_ext, shamt);
      sum_e = acc_e_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_m_d = acc_m_q;
    acc_e_d = acc_e_q;
    mout_d  = mout_q;
    eout_d  = eout_q;
    valid_d = valid_q;
    if (out_fire) begin
      state_d = ACCUM;
      valid_d = 1'b0;
    end
    if (in_fire) begin
      if (cnt_q == CNT_LAST) begin
        mout_d  = sum_m;
        eout_d  = OEW'($signed(sum_e));
        valid_d = 1'b1;
        state_d = HOLD;
        cnt_d   = '0;
      end else begin
        acc_m_d = sum_m;
        acc_e_d = sum_e;
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      acc_m_q <= '0;
      acc_e_q <= '0;
      mout_q  <= '0;
      eout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_m_q <= acc_m_d;
      acc_e_q <= acc_e_d;
      mout_q  <= mout_d;
      eout_q  <= eout_d;
      valid_q <= valid_d;
    end
  end

endmodule
